// File: rtl/forest_result_selector.sv
// Picks the argmax label from a snapshot of vote counts, or forwards a regression value; one result at a time over valid/ready.
// Latency: N_LABELS cycles for classification, 1 cycle for regression. Inputs arriving while busy are dropped and flagged on o_overrun.
module forest_result_selector #(
    parameter int N_LABELS   = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int LABEL_W    = (N_LABELS > 1) ? $clog2(N_LABELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_LABELS*FIFO_WIDTH-1:0] i_clf_accum_reg,
    input  logic [N_LABELS-1:0]            i_clf_accum_reg_vld,
    input  logic [FIFO_WIDTH-1:0]          i_rgs_accum_reg,
    input  logic                           i_rgs_accum_reg_vld,
    output logic [FIFO_WIDTH-1:0]          o_res_data,
    output logic                           o_res_is_clf,
    output logic                           o_res_vld,
    input  logic                           i_res_rdy,
    output logic                           o_busy,
    output logic                           o_overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    localparam logic [LABEL_W-1:0] LAST_IDX = LABEL_W'(N_LABELS - 1);

    state_t                  state_q, state_d;
    logic [FIFO_WIDTH-1:0]   snap_q [N_LABELS];
    logic [FIFO_WIDTH-1:0]   snap_d [N_LABELS];
    logic [FIFO_WIDTH-1:0]   best_val_q, best_val_d;
    logic [LABEL_W-1:0]      best_idx_q, best_idx_d;
    logic [LABEL_W-1:0]      scan_idx_q, scan_idx_d;
    logic [FIFO_WIDTH-1:0]   res_data_q, res_data_d;
    logic                    res_is_clf_q, res_is_clf_d;
    logic                    res_vld_q, res_vld_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;

    logic                    accept, clf_evt, rgs_evt, take;
    logic [FIFO_WIDTH-1:0]   scan_val, nb_val;
    logic [LABEL_W-1:0]      nb_idx;

    always_comb begin
        clf_evt  = |i_clf_accum_reg_vld;
        rgs_evt  = i_rgs_accum_reg_vld;
        accept   = (state_q == IDLE) || (state_q == OUT && res_vld_q && i_res_rdy);
        scan_val = snap_q[scan_idx_q];
        // Strict compare keeps the lower index on ties.
        take     = scan_val > best_val_q;
        nb_val   = take ? scan_val : best_val_q;
        nb_idx   = take ? scan_idx_q : best_idx_q;

        state_d      = state_q;
        snap_d       = snap_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        scan_idx_d   = scan_idx_q;
        res_data_d   = res_data_q;
        res_is_clf_d = res_is_clf_q;
        res_vld_d    = res_vld_q;
        overrun_d    = 1'b0;

        case (state_q)
            SCAN: begin
                overrun_d  = clf_evt || rgs_evt;
                best_val_d = nb_val;
                best_idx_d = nb_idx;
                scan_idx_d = scan_idx_q + LABEL_W'(1);
                if (scan_idx_q == LAST_IDX) begin
                    res_data_d   = FIFO_WIDTH'(nb_idx);
                    res_is_clf_d = 1'b1;
                    res_vld_d    = 1'b1;
                    state_d      = OUT;
                end
            end
            OUT: begin
                if (i_res_rdy) begin
                    res_vld_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    overrun_d = clf_evt || rgs_evt;
                end
            end
            default: ;
        endcase

        // A new event may be taken in the same cycle a pending result is handed off.
        if (accept) begin
            if (clf_evt) begin
                for (int i = 0; i < N_LABELS; i++)
                    snap_d[i] = i_clf_accum_reg[i*FIFO_WIDTH +: FIFO_WIDTH];
                best_val_d = i_clf_accum_reg[FIFO_WIDTH-1:0];
                best_idx_d = '0;
                scan_idx_d = LABEL_W'(1);
                overrun_d  = rgs_evt;
                if (N_LABELS == 1) begin
                    res_data_d   = '0;
                    res_is_clf_d = 1'b1;
                    res_vld_d    = 1'b1;
                    state_d      = OUT;
                end else begin
                    res_vld_d = 1'b0;
                    state_d   = SCAN;
                end
            end else if (rgs_evt) begin
                res_data_d   = i_rgs_accum_reg;
                res_is_clf_d = 1'b0;
                res_vld_d    = 1'b1;
                state_d      = OUT;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < N_LABELS; i++) snap_q[i] <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            scan_idx_q   <= '0;
            res_data_q   <= '0;
            res_is_clf_q <= 1'b0;
            res_vld_q    <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            scan_idx_q   <= scan_idx_d;
            res_data_q   <= res_data_d;
            res_is_clf_q <= res_is_clf_d;
            res_vld_q    <= res_vld_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_res_data   = res_data_q;
    assign o_res_is_clf = res_is_clf_q;
    assign o_res_vld    = res_vld_q;
    assign o_busy       = busy_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_forest_result_selector.sv
// Directed bench for forest_result_selector with N_LABELS=4, FIFO_WIDTH=16.
module tb_forest_result_selector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] clf_reg = '0;
    logic [3:0]  clf_vld = '0;
    logic [15:0] rgs_reg = '0;
    logic        rgs_vld = 1'b0;
    logic [15:0] res_data;
    logic        res_is_clf, res_vld, res_rdy = 1'b0, busy, overrun;

    int total  = 0;
    int passed = 0;

    forest_result_selector #(.N_LABELS(4), .FIFO_WIDTH(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_clf_accum_reg     (clf_reg),
        .i_clf_accum_reg_vld (clf_vld),
        .i_rgs_accum_reg     (rgs_reg),
        .i_rgs_accum_reg_vld (rgs_vld),
        .o_res_data          (res_data),
        .o_res_is_clf        (res_is_clf),
        .o_res_vld           (res_vld),
        .i_res_rdy           (res_rdy),
        .o_busy              (busy),
        .o_overrun           (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_counts(input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3);
        clf_reg = {c3, c2, c1, c0};
    endtask

    // Pulse classification valid, wait out the scan, check the label, then drain.
    task automatic run_clf(input string tag, input logic [15:0] exp_idx);
        clf_vld = 4'hF;
        tick();
        clf_vld = 4'h0;
        tick(); tick();
        chk({tag, "_vld_early"}, {31'd0, res_vld}, 32'd0);
        tick();
        chk({tag, "_vld"}, {31'd0, res_vld}, 32'd1);
        chk({tag, "_data"}, {16'd0, res_data}, {16'd0, exp_idx});
        chk({tag, "_is_clf"}, {31'd0, res_is_clf}, 32'd1);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk({tag, "_drain"}, {31'd0, res_vld}, 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_data", {16'd0, res_data}, 32'd0);
        chk("rst_vld", {31'd0, res_vld}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_is_clf", {31'd0, res_is_clf}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: argmax with latency 4, hold under backpressure, drop while holding
        set_counts(16'd3, 16'd9, 16'd2, 16'd5);
        clf_vld = 4'hF;
        tick();
        clf_vld = 4'h0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_vld_t1", {31'd0, res_vld}, 32'd0);
        tick(); tick();
        chk("t1_vld_t3", {31'd0, res_vld}, 32'd0);
        tick();
        chk("t1_vld_t4", {31'd0, res_vld}, 32'd1);
        chk("t1_data", {16'd0, res_data}, 32'd1);
        chk("t1_is_clf", {31'd0, res_is_clf}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rgs_reg = 16'h5555;
                rgs_vld = 1'b1;
            end
            tick();
            rgs_vld = 1'b0;
            chk("t1_hold_vld", {31'd0, res_vld}, 32'd1);
            chk("t1_hold_data", {16'd0, res_data}, 32'd1);
            chk("t1_hold_ovr", {31'd0, overrun}, (i == 2) ? 32'd1 : 32'd0);
        end
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk("t1_clear_vld", {31'd0, res_vld}, 32'd0);
        chk("t1_clear_busy", {31'd0, busy}, 32'd0);

        // 2: ties and unsigned compare
        set_counts(16'd7, 16'd7, 16'd0, 16'd7);
        run_clf("t2_tie", 16'd0);
        set_counts(16'd0, 16'd0, 16'd0, 16'd0);
        run_clf("t2_zero", 16'd0);
        set_counts(16'd0, 16'd0, 16'd0, 16'hFFFF);
        run_clf("t2_unsigned", 16'd3);

        // 3: regression forwarding
        rgs_reg = 16'hBEEF;
        rgs_vld = 1'b1;
        tick();
        rgs_vld = 1'b0;
        chk("t3_vld", {31'd0, res_vld}, 32'd1);
        chk("t3_data", {16'd0, res_data}, 32'h0000BEEF);
        chk("t3_is_clf", {31'd0, res_is_clf}, 32'd0);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk("t3_clear", {31'd0, res_vld}, 32'd0);

        // 4a: simultaneous clf and rgs in IDLE
        set_counts(16'd1, 16'd2, 16'd8, 16'd3);
        rgs_reg = 16'h1111;
        clf_vld = 4'h4;
        rgs_vld = 1'b1;
        tick();
        clf_vld = 4'h0;
        rgs_vld = 1'b0;
        chk("t4a_ovr", {31'd0, overrun}, 32'd1);
        tick();
        chk("t4a_ovr_off", {31'd0, overrun}, 32'd0);
        tick(); tick();
        chk("t4a_vld", {31'd0, res_vld}, 32'd1);
        chk("t4a_data", {16'd0, res_data}, 32'd2);
        chk("t4a_is_clf", {31'd0, res_is_clf}, 32'd1);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;

        // 4b: rgs pulse during SCAN is dropped
        set_counts(16'd5, 16'd1, 16'd1, 16'd6);
        clf_vld = 4'h1;
        tick();
        clf_vld = 4'h0;
        rgs_vld = 1'b1;
        tick();
        rgs_vld = 1'b0;
        chk("t4b_ovr", {31'd0, overrun}, 32'd1);
        tick();
        chk("t4b_ovr_off", {31'd0, overrun}, 32'd0);
        tick();
        chk("t4b_vld", {31'd0, res_vld}, 32'd1);
        chk("t4b_data", {16'd0, res_data}, 32'd3);
        chk("t4b_is_clf", {31'd0, res_is_clf}, 32'd1);
        res_rdy = 1'b1;
        tick();

        // 5a: rdy high, rgs accepted in the handshake cycle of a clf result
        set_counts(16'd4, 16'd0, 16'd0, 16'd0);
        clf_vld = 4'hF;
        tick();
        clf_vld = 4'h0;
        tick(); tick();
        chk("t5a_vld_early", {31'd0, res_vld}, 32'd0);
        tick();
        chk("t5a_clf_vld", {31'd0, res_vld}, 32'd1);
        chk("t5a_clf_data", {16'd0, res_data}, 32'd0);
        rgs_reg = 16'h1234;
        rgs_vld = 1'b1;
        tick();
        rgs_vld = 1'b0;
        chk("t5a_b2b_vld", {31'd0, res_vld}, 32'd1);
        chk("t5a_b2b_data", {16'd0, res_data}, 32'h00001234);
        chk("t5a_b2b_is_clf", {31'd0, res_is_clf}, 32'd0);
        chk("t5a_b2b_ovr", {31'd0, overrun}, 32'd0);
        tick();
        chk("t5a_done", {31'd0, res_vld}, 32'd0);
        res_rdy = 1'b0;

        // 5b: input change mid-SCAN does not leak into the result
        set_counts(16'd1, 16'd2, 16'd3, 16'd4);
        clf_vld = 4'hF;
        tick();
        clf_vld = 4'h0;
        set_counts(16'd9, 16'd0, 16'd0, 16'd0);
        tick(); tick(); tick();
        chk("t5b_vld", {31'd0, res_vld}, 32'd1);
        chk("t5b_data", {16'd0, res_data}, 32'd3);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;

        // 6: async reset mid-SCAN, then a clean run
        set_counts(16'd0, 16'd5, 16'd0, 16'd0);
        clf_vld = 4'hF;
        tick();
        clf_vld = 4'h0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_vld", {31'd0, res_vld}, 32'd0);
        chk("t6_rst_data", {16'd0, res_data}, 32'd0);
        chk("t6_rst_is_clf", {31'd0, res_is_clf}, 32'd0);
        chk("t6_rst_ovr", {31'd0, overrun}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_idle_vld", {31'd0, res_vld}, 32'd0);
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        set_counts(16'd2, 16'd0, 16'd7, 16'd1);
        run_clf("t6_fresh", 16'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
